// File: rtl/l2_cache_miss_scheduler_pkg.sv
// Shared types for the L2 miss scheduler: line index, requester id and drain state.
package l2_cache_miss_scheduler_pkg;

  localparam int L2_NUM_REQUESTERS = 4;
  localparam int L2_LINE_INDEX_W   = 26;

  typedef logic [L2_LINE_INDEX_W-1:0]            cache_line_index_t;
  typedef logic [$clog2(L2_NUM_REQUESTERS)-1:0]  l2_requester_id_t;

  typedef enum logic [1:0] {
    SCHED_RUN   = 2'd0,
    SCHED_DRAIN = 2'd1,
    SCHED_DONE  = 2'd2
  } scheduler_state_t;

endpackage

// File: rtl/l2_cache_miss_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from the pointer, pointer
// advances past the winner only when update_lru is asserted.
module rr_arbiter #(
  parameter int NUM_REQUESTS = 4,
  localparam int PTR_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQUESTS-1:0] request,
  input  logic                    update_lru,
  output logic [NUM_REQUESTS-1:0] grant
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  int               idx_int;

  always_comb begin
    grant   = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    idx_int = 0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      idx_int = int'(ptr_q) + i;
      if (idx_int >= NUM_REQUESTS) idx_int = idx_int - NUM_REQUESTS;
      idx = PTR_W'(idx_int);
      if (request[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
        ptr_d      = (idx_int == NUM_REQUESTS - 1) ? '0 : PTR_W'(idx_int + 1);
      end
    end
    if (!update_lru) ptr_d = ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/l2_cache_miss_scheduler.sv
// L2 pipeline-entry scheduler: fill-priority arbitration, credit throttling of
// core requests against the miss CAM, and a drain handshake for quiescence.
module l2_cache_miss_scheduler
  import l2_cache_miss_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = L2_NUM_REQUESTERS,
  parameter int QUEUE_SIZE     = 16,
  parameter int COUNT_WIDTH    = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] core_request_valid,
  input  cache_line_index_t         core_request_addr [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] core_request_ack,
  input  logic                      fill_valid,
  input  cache_line_index_t         fill_addr,
  output logic                      fill_ack,
  input  logic                      pipe_stall,
  output logic                      pipe_request_valid,
  output cache_line_index_t         pipe_request_addr,
  output logic                      pipe_is_fill,
  output l2_requester_id_t          pipe_requester_id,
  input  logic                      core_resolved,
  input  logic                      miss_enqueued,
  input  logic                      fill_retired,
  input  logic                      drain_request,
  output logic                      drain_done,
  output logic [COUNT_WIDTH-1:0]    outstanding
);

  scheduler_state_t           state_q, state_d;
  logic [COUNT_WIDTH-1:0]     inflight_q, inflight_d;
  logic [COUNT_WIDTH-1:0]     pending_q, pending_d;
  logic [COUNT_WIDTH:0]       outstanding_wide;

  logic                       pipe_valid_q, pipe_valid_d;
  cache_line_index_t          pipe_addr_q, pipe_addr_d;
  logic                       pipe_fill_q, pipe_fill_d;
  l2_requester_id_t           pipe_id_q, pipe_id_d;

  logic                       credit_ok;
  logic                       core_eligible;
  logic [NUM_REQUESTERS-1:0]  core_req_masked;
  logic [NUM_REQUESTERS-1:0]  core_grant_vec;
  logic                       core_grant;
  l2_requester_id_t           grant_id;
  cache_line_index_t          grant_addr;

  assign outstanding_wide = {1'b0, inflight_q} + {1'b0, pending_q};
  assign outstanding      = outstanding_wide[COUNT_WIDTH-1:0];

  // Credits are judged on the registered counters only, so a grant this cycle
  // can never push the CAM past capacity even if a miss is enqueued alongside.
  assign credit_ok       = (outstanding < COUNT_WIDTH'(QUEUE_SIZE));
  assign core_eligible   = reset && !pipe_stall && !fill_valid &&
                           (state_q == SCHED_RUN) && credit_ok;
  assign core_req_masked = core_eligible ? core_request_valid : '0;

  rr_arbiter #(
    .NUM_REQUESTS (NUM_REQUESTERS)
  ) u_rr_arbiter (
    .clk        (clk),
    .reset      (reset),
    .request    (core_req_masked),
    .update_lru (core_grant),
    .grant      (core_grant_vec)
  );

  assign core_grant       = |core_grant_vec;
  assign core_request_ack = core_grant_vec;
  assign fill_ack         = reset && !pipe_stall && fill_valid;

  always_comb begin
    grant_id   = '0;
    grant_addr = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (core_grant_vec[i]) begin
        grant_id   = l2_requester_id_t'(i);
        grant_addr = core_request_addr[i];
      end
    end
  end

  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_addr_d  = pipe_addr_q;
    pipe_fill_d  = pipe_fill_q;
    pipe_id_d    = pipe_id_q;
    if (!pipe_stall) begin
      if (fill_ack) begin
        pipe_valid_d = 1'b1;
        pipe_addr_d  = fill_addr;
        pipe_fill_d  = 1'b1;
        pipe_id_d    = '0;
      end else if (core_grant) begin
        pipe_valid_d = 1'b1;
        pipe_addr_d  = grant_addr;
        pipe_fill_d  = 1'b0;
        pipe_id_d    = grant_id;
      end else begin
        pipe_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({core_grant, core_resolved})
      2'b10:   inflight_d = inflight_q + COUNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - COUNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase
    pending_d = pending_q;
    unique case ({miss_enqueued, fill_retired})
      2'b10:   pending_d = pending_q + COUNT_WIDTH'(1);
      2'b01:   pending_d = pending_q - COUNT_WIDTH'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCHED_RUN:   if (drain_request) state_d = SCHED_DRAIN;
      SCHED_DRAIN: begin
        if (!drain_request) state_d = SCHED_RUN;
        else if ((outstanding == '0) && !pipe_valid_q) state_d = SCHED_DONE;
      end
      SCHED_DONE:  if (!drain_request) state_d = SCHED_RUN;
      default:     state_d = SCHED_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SCHED_RUN;
      inflight_q   <= '0;
      pending_q    <= '0;
      pipe_valid_q <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_fill_q  <= 1'b0;
      pipe_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      pending_q    <= pending_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_fill_q  <= pipe_fill_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  assign pipe_request_valid = pipe_valid_q;
  assign pipe_request_addr  = pipe_addr_q;
  assign pipe_is_fill       = pipe_fill_q;
  assign pipe_requester_id  = pipe_id_q;
  assign drain_done         = (state_q == SCHED_DONE);

  always @(posedge clk) begin
    if (reset) begin
      a_inflight_underflow: assert (!(core_resolved && !core_grant && (inflight_q == '0)));
      a_pending_underflow:  assert (!(fill_retired && !miss_enqueued && (pending_q == '0)));
      a_credit_bound:       assert (outstanding_wide <= (COUNT_WIDTH + 1)'(QUEUE_SIZE));
    end
  end

endmodule

// File: tb/tb_l2_cache_miss_scheduler.sv
// Directed plus randomized bench for the L2 miss scheduler with a cycle-level reference model.
module tb_l2_cache_miss_scheduler;
  import l2_cache_miss_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        crv;
  cache_line_index_t cra [4];
  logic [3:0]        cack;
  logic              fv;
  cache_line_index_t faddr;
  logic              fack;
  logic              stall;
  logic              pv;
  cache_line_index_t paddr;
  logic              pfill;
  l2_requester_id_t  pid;
  logic              cres, menq, fret, drq;
  logic              ddone;
  logic [4:0]        outst;

  always #5 clk = ~clk;

  l2_cache_miss_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .core_request_valid (crv),
    .core_request_addr  (cra),
    .core_request_ack   (cack),
    .fill_valid         (fv),
    .fill_addr          (faddr),
    .fill_ack           (fack),
    .pipe_stall         (stall),
    .pipe_request_valid (pv),
    .pipe_request_addr  (paddr),
    .pipe_is_fill       (pfill),
    .pipe_requester_id  (pid),
    .core_resolved      (cres),
    .miss_enqueued      (menq),
    .fill_retired       (fret),
    .drain_request      (drq),
    .drain_done         (ddone),
    .outstanding        (outst)
  );

  // Reference model: counters, round-robin pointer, drain mode (0 run, 1 drain, 2 done),
  // and the expected contents of the issue register.
  int                m_inflight, m_pending, m_ptr, m_mode, m_id;
  bit                m_pv, m_fill;
  cache_line_index_t m_addr;
  int                last_g;
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_pending = 0; m_ptr = 0; m_mode = 0; m_id = 0;
    m_pv = 0; m_fill = 0; m_addr = '0; last_g = -1;
  endtask

  task automatic cycle();
    int         g, j, out;
    bit         old_pv;
    logic [3:0] exp_ack;
    @(negedge clk);
    out = m_inflight + m_pending;
    g = -1;
    if (!stall && !fv && m_mode == 0 && out < 16)
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (g < 0 && crv[j]) g = j;
      end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("core_ack", 32'(cack), 32'(exp_ack));
    chk("fill_ack", 32'(fack), 32'(!stall && fv));
    chk("outstanding", 32'(outst), 32'(out));
    chk("drain_done", 32'(ddone), 32'(m_mode == 2));
    chk("pipe_valid", 32'(pv), 32'(m_pv));
    if (m_pv) begin
      chk("pipe_addr", 32'(paddr), 32'(m_addr));
      chk("pipe_is_fill", 32'(pfill), 32'(m_fill));
      chk("pipe_id", 32'(pid), 32'(m_id));
    end
    old_pv = m_pv;
    last_g = g;
    if (!stall) begin
      if (fv) begin
        m_pv = 1; m_addr = faddr; m_fill = 1; m_id = 0;
      end else if (g >= 0) begin
        m_pv = 1; m_addr = cra[g]; m_fill = 0; m_id = g;
        m_ptr = (g + 1) % 4;
      end else m_pv = 0;
    end
    m_inflight = m_inflight + ((g >= 0) ? 1 : 0) - (cres ? 1 : 0);
    m_pending  = m_pending + (menq ? 1 : 0) - (fret ? 1 : 0);
    case (m_mode)
      0: if (drq) m_mode = 1;
      1: if (!drq) m_mode = 0; else if (out == 0 && !old_pv) m_mode = 2;
      default: if (!drq) m_mode = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle; resolve/retire are masked so the counters never underflow.
  task automatic step(input logic [3:0] v, input bit f, input bit st, input bit res,
                      input bit enq, input bit ret, input bit dr);
    for (int i = 0; i < 4; i++) cra[i] = cache_line_index_t'($urandom);
    faddr = cache_line_index_t'($urandom);
    crv   = v;
    fv    = f;
    stall = st;
    cres  = res && (m_inflight > 0);
    menq  = enq && cres;
    fret  = ret && (m_pending > 0);
    drq   = dr;
    cycle();
  endtask

  task automatic drain_down();
    for (int i = 0; i < 80 && (m_inflight + m_pending) > 0; i++) step(4'h0, 0, 0, 1, 0, 1, 0);
    chk("drain_down_bound", 32'(outst), 32'd0);
  endtask

  task automatic build_to(input int target);
    for (int i = 0; i < 30; i++)
      step(((m_inflight + m_pending) < target) ? 4'hF : 4'h0, 0, 0, 1, (m_pending < target), 0, 0);
  endtask

  int grants;
  bit rdrq;

  initial begin
    reset = 1'b0;
    crv = '0; fv = 0; stall = 0; cres = 0; menq = 0; fret = 0; drq = 0;
    faddr = '0;
    for (int i = 0; i < 4; i++) cra[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(cack), 32'd0);
    chk("rst_fill_ack", 32'(fack), 32'd0);
    chk("rst_pv", 32'(pv), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pfill", 32'(pfill), 32'd0);
    chk("rst_pid", 32'(pid), 32'd0);
    chk("rst_drain_done", 32'(ddone), 32'd0);
    chk("rst_outstanding", 32'(outst), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Round-robin across all four ports with every grant resolved.
    for (int k = 0; k < 6; k++) begin
      step(4'hF, 0, 0, 1, 0, 0, 0);
      chk("rr_order", 32'(last_g), 32'(k % 4));
    end
    step(4'h0, 0, 0, 1, 0, 0, 0);

    // Fill priority; pointer (now 2) must not move on the fill.
    step(4'b0011, 1, 0, 0, 0, 0, 0);
    chk("fill_blocks_core", 32'(last_g), 32'hFFFF_FFFF);
    step(4'b1111, 0, 0, 0, 0, 0, 0);
    chk("ptr_held_over_fill", 32'(last_g), 32'd2);
    step(4'h0, 0, 0, 1, 0, 0, 0);

    // Credit exhaustion.
    for (int i = 0; i < 60 && !(m_inflight == 0 && m_pending == 16); i++) step(4'hF, 0, 0, 1, 1, 0, 0);
    chk("credit_full", 32'(outst), 32'd16);
    grants = 0;
    repeat (3) begin step(4'hF, 0, 0, 0, 0, 0, 0); if (last_g >= 0) grants++; end
    chk("credit_blocked", 32'(grants), 32'd0);
    step(4'hF, 0, 0, 0, 0, 1, 0);
    if (last_g >= 0) grants++;
    repeat (4) begin step(4'hF, 0, 0, 1, 1, 0, 0); if (last_g >= 0) grants++; end
    chk("credit_one_more", 32'(grants), 32'd1);
    drain_down();

    // Stall holds the issue register; grant resumes on the unstalled cycle.
    step(4'hF, 0, 0, 1, 0, 0, 0);
    grants = 0;
    repeat (3) begin step(4'hF, 0, 1, 1, 0, 0, 0); if (last_g >= 0) grants++; end
    chk("stall_no_ack", 32'(grants), 32'd0);
    step(4'hF, 0, 0, 1, 0, 0, 0);
    chk("stall_resume", 32'(last_g >= 0), 32'd1);
    drain_down();

    // Drain with three misses outstanding.
    build_to(3);
    step(4'hF, 0, 0, 1, 0, 0, 1);
    grants = 0;
    step(4'hF, 1, 0, 1, 0, 0, 1);
    chk("drain_fill_ack", 32'(fack), 32'd1);
    repeat (3) begin step(4'hF, 0, 0, 1, 0, 1, 1); if (last_g >= 0) grants++; end
    repeat (3) begin step(4'hF, 0, 0, 1, 0, 1, 1); if (last_g >= 0) grants++; end
    chk("drain_no_core", 32'(grants), 32'd0);
    chk("drain_done_high", 32'(ddone), 32'd1);
    step(4'hF, 0, 0, 0, 0, 0, 0);
    step(4'hF, 0, 0, 1, 0, 0, 0);
    chk("drain_exit_grant", 32'(last_g >= 0), 32'd1);
    drain_down();

    // Randomized traffic.
    rdrq = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) rdrq = !rdrq;
      step(4'($urandom), ($urandom_range(4) == 0), ($urandom_range(5) == 0),
           $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(2) == 0, rdrq);
    end
    step(4'h0, 0, 0, 0, 0, 0, 0);
    step(4'h0, 0, 0, 0, 0, 0, 0);
    drain_down();

    // Asynchronous reset mid-run.
    build_to(5);
    chk("pre_reset_outstanding", 32'(outst), 32'd5);
    crv = 4'hF;
    reset = 1'b0;
    #2;
    chk("async_rst_outstanding", 32'(outst), 32'd0);
    chk("async_rst_ack", 32'(cack), 32'd0);
    chk("async_rst_pv", 32'(pv), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_edge_outstanding", 32'(outst), 32'd0);
    chk("rst_edge_drain_done", 32'(ddone), 32'd0);
    reset = 1'b1;
    model_reset();
    repeat (5) step(4'($urandom), 0, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
